// File: rtl/mux2_pkg.sv
// Shared defaults and types for the mux2 steering block.
package mux2_pkg;

    localparam int unsigned MUX2_WIDTH = 1;
    localparam int unsigned MUX2_CNT_W = 8;

    typedef logic [MUX2_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mux2_core.sv
// Combinational WIDTH-bit 2:1 selector: y follows b when select is high, else a.
module mux2_core
    import mux2_pkg::*;
#(
    parameter int unsigned WIDTH = MUX2_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = select ? b : a;
    end

endmodule

// File: rtl/mux2.sv
// 2:1 datapath selector with a registered output copy, registered select and a
// saturating select-toggle counter. Define MUX2_PARITY_EN to add registered parity y_par.
module mux2
    import mux2_pkg::*;
#(
    parameter int unsigned WIDTH = MUX2_WIDTH,
    parameter int unsigned CNT_W = MUX2_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] toggle_cnt
`ifdef MUX2_PARITY_EN
    ,
    output logic             y_par
`endif
);

    mux2_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a     (a),
        .b     (b),
        .select(select),
        .y     (y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            sel_q <= 1'b0;
        end else begin
            y_q   <= y;
            sel_q <= select;
        end
    end

    // Only the value sampled at the edge counts, so intra-cycle glitches are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_cnt <= '0;
        end else if ((select != sel_q) && (toggle_cnt != '1)) begin
            toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end

`ifdef MUX2_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par <= 1'b0;
        end else begin
            y_par <= ^y;
        end
    end
`endif

endmodule

// File: tb/tb_mux2.sv
// Directed and randomized checks of mux2 (WIDTH=4, CNT_W=2) against a behavioural model.
module tb_mux2;

    localparam int unsigned W       = 4;
    localparam int unsigned CW      = 2;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          select;
    logic [W-1:0]  y;
    logic [W-1:0]  y_q;
    logic          sel_q;
    logic [CW-1:0] toggle_cnt;
`ifdef MUX2_PARITY_EN
    logic          y_par;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: unbounded toggle tally, clipped at the counter maximum when compared.
    logic [W-1:0] m_yq      = '0;
    logic         m_sel     = 1'b0;
    int           m_toggles = 0;

    mux2 #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .select    (select),
        .y         (y),
        .y_q       (y_q),
        .sel_q     (sel_q),
        .toggle_cnt(toggle_cnt)
`ifdef MUX2_PARITY_EN
        ,
        .y_par     (y_par)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_yq      = '0;
            m_sel     = 1'b0;
            m_toggles = 0;
        end else begin
            if (select !== m_sel) m_toggles++;
            m_sel = select;
            m_yq  = select ? b : a;
        end
    end

    function automatic int exp_cnt();
        return (m_toggles > CNT_MAX) ? CNT_MAX : m_toggles;
    endfunction

    function automatic logic [W-1:0] exp_y();
        return select ? b : a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".y_q"}, 32'(y_q), 32'(m_yq));
        chk({tag, ".sel_q"}, 32'(sel_q), 32'(m_sel));
        chk({tag, ".cnt"}, 32'(toggle_cnt), 32'(exp_cnt()));
`ifdef MUX2_PARITY_EN
        chk({tag, ".y_par"}, 32'(y_par), 32'(^m_yq));
`endif
    endtask

    initial begin
        int sat_exp [6];
        sat_exp = '{1, 2, 3, 3, 3, 3};

        rst_n  = 1'b0;
        a      = '0;
        b      = '0;
        select = 1'b0;
        #2;
        chk("reset.y_q", 32'(y_q), 32'd0);
        chk("reset.sel_q", 32'(sel_q), 32'd0);
        chk("reset.cnt", 32'(toggle_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Truth-table walk on bit 0, 5 ns steps, checked 2 ns after each change
        @(negedge clk);
        a = 4'd0; b = 4'd0; select = 1'b0; #2; chk("tt0", 32'(y), 32'(exp_y())); #3;
        a = 4'd1;                          #2; chk("tt1", 32'(y), 32'(exp_y())); #3;
        select = 1'b1;                     #2; chk("tt2", 32'(y), 32'(exp_y())); #3;
        b = 4'd1;                          #2; chk("tt3", 32'(y), 32'(exp_y())); #3;
        a = 4'd0;                          #2; chk("tt4", 32'(y), 32'(exp_y())); #3;

        // Registered path: y changes at once, y_q one edge later
        @(negedge clk);
        a = 4'd1; b = 4'd0; select = 1'b0;
        @(posedge clk); #1;
        chk("reg.y_q_hi", 32'(y_q), 32'd1);
        chk_regs("reg.pre");
        @(negedge clk);
        select = 1'b1; #1;
        chk("reg.y_now", 32'(y), 32'd0);
        chk("reg.y_q_hold", 32'(y_q), 32'd1);
        @(posedge clk); #1;
        chk("reg.y_q_lo", 32'(y_q), 32'd0);

        // Fresh reset so the counter starts from zero
        @(negedge clk);
        rst_n = 1'b0; select = 1'b0; a = 4'd1; b = 4'd1;
        #1; chk_regs("rst2");
        @(negedge clk);
        rst_n = 1'b1;

        // Glitch within one period must not count
        @(negedge clk);
        #1 select = 1'b1;
        #2 select = 1'b0;
        @(posedge clk); #1;
        chk("glitch.cnt", 32'(toggle_cnt), 32'd0);
        chk("glitch.sel_q", 32'(sel_q), 32'd0);

        // Saturation: toggle every cycle for six cycles
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            select = ~select;
            @(posedge clk); #1;
            chk($sformatf("sat%0d", i), 32'(toggle_cnt), 32'(sat_exp[i]));
            chk_regs($sformatf("sat%0d.m", i));
        end

        // Async reset between edges with y_q=1, toggle_cnt=3
        chk("arst.pre_yq", 32'(y_q), 32'd1);
        chk("arst.pre_cnt", 32'(toggle_cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.y_q", 32'(y_q), 32'd0);
        chk("arst.sel_q", 32'(sel_q), 32'd0);
        chk("arst.cnt", 32'(toggle_cnt), 32'd0);
        a = 4'd6; #1;
        chk("arst.y", 32'(y), 32'(exp_y()));
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MUX2_PARITY_EN
        @(negedge clk);
        a = 4'b1011; select = 1'b0;
        @(posedge clk); #1;
        chk("par.1011", 32'(y_par), 32'd1);
        @(negedge clk);
        a = 4'b1001;
        @(posedge clk); #1;
        chk("par.1001", 32'(y_par), 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            a      = W'($urandom);
            b      = W'($urandom);
            select = ($urandom_range(0, 2) != 0) ? ~select : select;
            #2;
            chk($sformatf("rnd%0d.y", i), 32'(y), 32'(exp_y()));
            @(posedge clk); #1;
            chk_regs($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
